// File: rtl/rotate_tile_ctrl_pkg.sv
// Shared constants, state encoding and rotation-kind helper for the tile rotation controller.
package rotate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4
    } rc_state_t;

    localparam logic [1:0] P_DEG_0   = 2'd0;
    localparam logic [1:0] P_DEG_90  = 2'd1;
    localparam logic [1:0] P_DEG_180 = 2'd2;
    localparam logic [1:0] P_DEG_270 = 2'd3;

    localparam int unsigned TILE_DIM        = 8;
    localparam int unsigned BEATS_PER_ROW   = 8;
    localparam int unsigned BEATS_PER_TILE  = 64;
    localparam int unsigned BYTES_PER_PIXEL = 3;

    localparam int unsigned DIM_W  = 16;
    localparam int unsigned IDX_W  = 13;
    localparam int unsigned BEAT_W = 6;

    localparam logic [IDX_W-1:0] IDX_ONE = 13'd1;

    typedef enum logic [1:0] {
        MAP_IDENT = 2'd0,
        MAP_CW    = 2'd1,
        MAP_CCW   = 2'd2,
        MAP_HALF  = 2'd3
    } rc_map_t;

    // A quarter turn one way equals three quarter turns the other way.
    function automatic rc_map_t map_kind(input logic [1:0] deg, input logic ccw);
        rc_map_t kind;
        case (deg)
            P_DEG_90:  kind = ccw ? MAP_CCW : MAP_CW;
            P_DEG_180: kind = MAP_HALF;
            P_DEG_270: kind = ccw ? MAP_CW : MAP_CCW;
            default:   kind = MAP_IDENT;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/rotate_tile_ctrl_if.sv
// Job control and DMA request bundle between the rotation controller and its host/DMA engine.
interface rotate_tile_ctrl_if;
    logic        I_RC_START;
    logic        I_RC_ABORT;
    logic [15:0] I_RC_WIDTH;
    logic [15:0] I_RC_HEIGHT;
    logic [1:0]  I_RC_DEGREES;
    logic        I_RC_DIRECTION;
    logic [31:0] I_RC_SRC_BASE;
    logic [31:0] I_RC_DST_BASE;
    logic        I_RC_DMA_READY;
    logic        O_RC_BUSY;
    logic        O_RC_DONE;
    logic        O_RC_ERR;
    logic        O_RC_CP_START;
    logic        O_RC_DMA_REQ;
    logic        O_RC_DMA_WRITE;
    logic [31:0] O_RC_DMA_ADDR;
    logic [12:0] O_RC_TILE_X;
    logic [12:0] O_RC_TILE_Y;

    modport slave (
        input  I_RC_START, I_RC_ABORT, I_RC_WIDTH, I_RC_HEIGHT, I_RC_DEGREES,
               I_RC_DIRECTION, I_RC_SRC_BASE, I_RC_DST_BASE, I_RC_DMA_READY,
        output O_RC_BUSY, O_RC_DONE, O_RC_ERR, O_RC_CP_START, O_RC_DMA_REQ,
               O_RC_DMA_WRITE, O_RC_DMA_ADDR, O_RC_TILE_X, O_RC_TILE_Y
    );

    modport master (
        output I_RC_START, I_RC_ABORT, I_RC_WIDTH, I_RC_HEIGHT, I_RC_DEGREES,
               I_RC_DIRECTION, I_RC_SRC_BASE, I_RC_DST_BASE, I_RC_DMA_READY,
        input  O_RC_BUSY, O_RC_DONE, O_RC_ERR, O_RC_CP_START, O_RC_DMA_REQ,
               O_RC_DMA_WRITE, O_RC_DMA_ADDR, O_RC_TILE_X, O_RC_TILE_Y
    );
endinterface

// File: rtl/rotate_tile_ctrl_map.sv
// Maps a source tile index to its destination tile index and gives the rotated image width.
module rotate_tile_map
    import rotate_pkg::*;
(
    input  logic [IDX_W-1:0] tx_i,
    input  logic [IDX_W-1:0] ty_i,
    input  logic [IDX_W-1:0] tw_i,
    input  logic [IDX_W-1:0] th_i,
    input  logic [1:0]       deg_i,
    input  logic             dir_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic [IDX_W-1:0] dx_o,
    output logic [IDX_W-1:0] dy_o,
    output logic [DIM_W-1:0] out_width_o
);

    // Destination tile coordinates for the effective rotation.
    always_comb begin
        dx_o        = tx_i;
        dy_o        = ty_i;
        out_width_o = width_i;
        case (map_kind(deg_i, dir_i))
            MAP_CW: begin
                dx_o        = th_i - IDX_ONE - ty_i;
                dy_o        = tx_i;
                out_width_o = height_i;
            end
            MAP_CCW: begin
                dx_o        = ty_i;
                dy_o        = tw_i - IDX_ONE - tx_i;
                out_width_o = height_i;
            end
            MAP_HALF: begin
                dx_o = tw_i - IDX_ONE - tx_i;
                dy_o = th_i - IDX_ONE - ty_i;
            end
            default: begin
                dx_o = tx_i;
                dy_o = ty_i;
            end
        endcase
    end

endmodule

// File: rtl/rotate_tile_ctrl.sv
// Tile-by-tile rotation job sequencer: walks source tiles in raster order and issues
// row-addressed DMA reads of each source tile followed by writes to its rotated position.
module rotate_tile_ctrl
    import rotate_pkg::*;
#(
    parameter int unsigned P_TILE_DIM      = TILE_DIM,
    parameter int unsigned P_BEATS_PER_ROW = BEATS_PER_ROW
) (
    input  logic               I_RC_HCLK,
    input  logic               I_RC_HRESET,
    rotate_tile_ctrl_if.slave  bus
);

    localparam int unsigned      LP_TILE_BEATS = P_TILE_DIM * P_BEATS_PER_ROW;
    localparam logic [BEAT_W-1:0] LP_LAST_BEAT = BEAT_W'(LP_TILE_BEATS - 1);

    rc_state_t         state_q;
    logic              busy_q, done_q, err_q, cp_start_q, req_q, wr_q;
    logic [31:0]       addr_q;
    logic [IDX_W-1:0]  tx_q, ty_q;
    logic [BEAT_W-1:0] beat_q;
    logic [DIM_W-1:0]  width_q, height_q;
    logic [1:0]        deg_q;
    logic              dir_q;
    logic [31:0]       src_q, dst_q;

    logic [IDX_W-1:0]  tw_s, th_s, dx_s, dy_s, tx_d, ty_d;
    logic [DIM_W-1:0]  out_w_s;
    logic [BEAT_W-1:0] beat_d;
    logic [31:0]       src_tile_s, dst_tile_s, src_stride_s, dst_stride_s;
    logic              cfg_bad_s, last_beat_s, row_end_s, last_tile_s;

    assign tw_s = IDX_W'(32'(width_q) / 32'(P_TILE_DIM));
    assign th_s = IDX_W'(32'(height_q) / 32'(P_TILE_DIM));

    rotate_tile_map u_map (
        .tx_i        (tx_q),
        .ty_i        (ty_q),
        .tw_i        (tw_s),
        .th_i        (th_s),
        .deg_i       (deg_q),
        .dir_i       (dir_q),
        .width_i     (width_q),
        .height_i    (height_q),
        .dx_o        (dx_s),
        .dy_o        (dy_s),
        .out_width_o (out_w_s)
    );

    assign cfg_bad_s = (bus.I_RC_WIDTH == 16'd0) || (bus.I_RC_HEIGHT == 16'd0)
                    || ((32'(bus.I_RC_WIDTH)  % 32'(P_TILE_DIM)) != 32'd0)
                    || ((32'(bus.I_RC_HEIGHT) % 32'(P_TILE_DIM)) != 32'd0);

    assign src_tile_s   = src_q + (32'(ty_q) * 32'(P_TILE_DIM) * 32'(width_q)
                                 + 32'(tx_q) * 32'(P_TILE_DIM)) * 32'(BYTES_PER_PIXEL);
    assign dst_tile_s   = dst_q + (32'(dy_s) * 32'(P_TILE_DIM) * 32'(out_w_s)
                                 + 32'(dx_s) * 32'(P_TILE_DIM)) * 32'(BYTES_PER_PIXEL);
    assign src_stride_s = 32'(width_q) * 32'(BYTES_PER_PIXEL);
    assign dst_stride_s = 32'(out_w_s) * 32'(BYTES_PER_PIXEL);

    assign beat_d      = beat_q + 6'd1;
    assign last_beat_s = (beat_q == LP_LAST_BEAT);
    assign row_end_s   = ((32'(beat_q) % 32'(P_BEATS_PER_ROW)) == 32'(P_BEATS_PER_ROW - 1));
    assign last_tile_s = (tx_q == tw_s - IDX_ONE) && (ty_q == th_s - IDX_ONE);
    assign tx_d        = (tx_q == tw_s - IDX_ONE) ? 13'd0 : tx_q + IDX_ONE;
    assign ty_d        = (tx_q == tw_s - IDX_ONE) ? ty_q + IDX_ONE : ty_q;

    // Job sequencer with registered outputs; abort takes priority over any DMA progress.
    always_ff @(posedge I_RC_HCLK) begin
        if (I_RC_HRESET) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cp_start_q <= 1'b0;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 32'd0;
            tx_q       <= 13'd0;
            ty_q       <= 13'd0;
            beat_q     <= 6'd0;
            width_q    <= 16'd0;
            height_q   <= 16'd0;
            deg_q      <= 2'd0;
            dir_q      <= 1'b0;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cp_start_q <= 1'b0;
            if (bus.I_RC_ABORT && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                req_q   <= 1'b0;
                wr_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.I_RC_START) begin
                            if (cfg_bad_s) begin
                                err_q <= 1'b1;
                            end else begin
                                width_q    <= bus.I_RC_WIDTH;
                                height_q   <= bus.I_RC_HEIGHT;
                                deg_q      <= bus.I_RC_DEGREES;
                                dir_q      <= bus.I_RC_DIRECTION;
                                src_q      <= bus.I_RC_SRC_BASE;
                                dst_q      <= bus.I_RC_DST_BASE;
                                tx_q       <= 13'd0;
                                ty_q       <= 13'd0;
                                beat_q     <= 6'd0;
                                busy_q     <= 1'b1;
                                cp_start_q <= 1'b1;
                                state_q    <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        state_q <= ST_READ;
                        req_q   <= 1'b1;
                        wr_q    <= 1'b0;
                        addr_q  <= src_tile_s;
                        beat_q  <= 6'd0;
                    end
                    ST_READ: begin
                        if (bus.I_RC_DMA_READY) begin
                            beat_q <= beat_d;
                            if (last_beat_s) begin
                                state_q <= ST_WRITE;
                                wr_q    <= 1'b1;
                                addr_q  <= dst_tile_s;
                            end else if (row_end_s) begin
                                addr_q <= addr_q + src_stride_s;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (bus.I_RC_DMA_READY) begin
                            beat_q <= beat_d;
                            if (last_beat_s) begin
                                state_q <= ST_NEXT;
                                req_q   <= 1'b0;
                                wr_q    <= 1'b0;
                            end else if (row_end_s) begin
                                addr_q <= addr_q + dst_stride_s;
                            end
                        end
                    end
                    ST_NEXT: begin
                        if (last_tile_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            tx_q       <= tx_d;
                            ty_q       <= ty_d;
                            cp_start_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        req_q   <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.O_RC_BUSY      = busy_q;
    assign bus.O_RC_DONE      = done_q;
    assign bus.O_RC_ERR       = err_q;
    assign bus.O_RC_CP_START  = cp_start_q;
    assign bus.O_RC_DMA_REQ   = req_q;
    assign bus.O_RC_DMA_WRITE = wr_q;
    assign bus.O_RC_DMA_ADDR  = addr_q;
    assign bus.O_RC_TILE_X    = tx_q;
    assign bus.O_RC_TILE_Y    = ty_q;

endmodule
